axi_cmd_gen: RTL and testbench
==============================

Name: axi_cmd_gen

Overview:
Command sequencer that sits directly upstream of the axi master block and drives its w_cmd and r_cmd request channels. On a single start pulse it splits a byte region into chunk-sized INCR commands. It first issues all write commands for the region, then all read commands for the same region. It reports busy/done and command counts for system-level sequencing and self-checking.

Parameters:
ADDR_WD, 32, address and length width in bits
DATA_WD, 32, AXI data width; sets cmd_size
STRB_WD, DATA_WD>>3, bytes per beat
GAP_CYCLES, 4, idle cycles between commands (used only with AXI_CMD_GEN_GAP_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to begin a sequence
base_addr  in  ADDR_WD  first byte address, sampled on accepted start
total_len  in  ADDR_WD  region size in bytes, sampled on accepted start
chunk_len  in  ADDR_WD  bytes per command, sampled on accepted start
busy  out  1  sequence in progress
done  out  1  one-cycle pulse when last read command is accepted
w_cmd_cnt  out  16  write commands accepted in current/last sequence
r_cmd_cnt  out  16  read commands accepted in current/last sequence
w_cmd_valid  out  1  write command valid
w_cmd_ready  in  1  write command accepted by axi block
w_cmd_addr  out  ADDR_WD  write command byte address
w_cmd_len  out  ADDR_WD  write command length in bytes
w_cmd_burst  out  2  constant 2'b01 (INCR)
w_cmd_size  out  3  constant $clog2(STRB_WD)
r_cmd_valid, r_cmd_ready, r_cmd_addr, r_cmd_len, r_cmd_burst, r_cmd_size: same as write set, for reads

Behaviour:
- Reset: busy=0, done=0, w_cmd_valid=0, r_cmd_valid=0, addr/len outputs=0, counts=0, state IDLE. Reset mid-sequence drops valids the next cycle with no completion pulse.
- States: IDLE, WR, RD, FIN.
- IDLE:
  - start=1 latches base_addr, total_len, chunk_len (chunk_len=0 is replaced by total_len), clears counts, sets busy.
  - total_len=0 goes to FIN directly, with no commands issued.
  - Otherwise goes to WR.
  - start is ignored while busy=1.
- WR:
  - w_cmd_valid is asserted the cycle after entry; registered output.
  - len = min(chunk, remaining); addr = current pointer.
  - While valid=1 and ready=0, addr/len/valid are held stable.
  - On valid&&ready: pointer += len (mod 2^ADDR_WD, wraps silently); remaining -= len; w_cmd_cnt++.
  - If remaining becomes 0: drop valid, reload pointer=base, remaining=total, go to RD. Otherwise present the next command in the next cycle (back-to-back; valid stays high).
- RD: identical to WR on the r_cmd channel. Accepting the last read command goes to FIN.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE. Counts are held until the next start.
- w_cmd_valid and r_cmd_valid are never high in the same cycle.
- The final short chunk carries the remainder bytes exactly; no rounding to beat size.
- Counters saturate at 16'hFFFF.
- Latency: start (cycle 0) -> first w_cmd_valid at cycle 2.

Optional Feature:
Macro AXI_CMD_GEN_GAP_EN.
- Defined: after each accepted command (write or read), valid stays low for GAP_CYCLES cycles before the next command is presented. This uses a down-counter loaded on handshake. GAP_CYCLES=0 behaves as undefined.
- Undefined: no gap counter is present; commands are back-to-back as described above.

Test Plan:
- base=0, total=0x1000, chunk=0x400, ready tied 1 -> writes at 0x0,0x400,0x800,0xC00 each len 0x400, then the same four reads; w_cmd_cnt=r_cmd_cnt=4; single done pulse; burst=01, size=2.
- base=0x100, total=0x A50, chunk=0x400 -> lens 0x400,0x400,0x250 at 0x100,0x500,0x900 on both channels.
- ready toggling randomly 30% -> addr/len stable while valid&&!ready; no command lost or duplicated; same sequence as ready=1.
- total=0 -> busy one cycle, done pulse, no valids, counts 0; chunk=0 with total=0x80 -> one write and one read of len 0x80.
- base=0xFFFFFC00, total=0x800, chunk=0x400 -> second address wraps to 0x00000000; start re-pulsed during WR is ignored.
- reset asserted while valid=1 in WR -> next cycle valid=0, busy=0, counts 0, no done; with AXI_CMD_GEN_GAP_EN and GAP_CYCLES=4 -> exactly 4 low-valid cycles between successive handshakes.

Source files
------------

// File: rtl/axi_cmd_gen.sv
// rtl/axi_cmd_gen.sv - splits a byte region into INCR write commands, then read commands, for the axi master
// Optional AXI_CMD_GEN_GAP_EN holds valid low for GAP_CYCLES cycles after every accepted command.
module axi_cmd_gen #(
  parameter int ADDR_WD    = 32,
  parameter int DATA_WD    = 32,
  parameter int STRB_WD    = DATA_WD >> 3,
  parameter int GAP_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_WD-1:0] base_addr,
  input  logic [ADDR_WD-1:0] total_len,
  input  logic [ADDR_WD-1:0] chunk_len,
  output logic               busy,
  output logic               done,
  output logic [15:0]        w_cmd_cnt,
  output logic [15:0]        r_cmd_cnt,
  output logic               w_cmd_valid,
  input  logic               w_cmd_ready,
  output logic [ADDR_WD-1:0] w_cmd_addr,
  output logic [ADDR_WD-1:0] w_cmd_len,
  output logic [1:0]         w_cmd_burst,
  output logic [2:0]         w_cmd_size,
  output logic               r_cmd_valid,
  input  logic               r_cmd_ready,
  output logic [ADDR_WD-1:0] r_cmd_addr,
  output logic [ADDR_WD-1:0] r_cmd_len,
  output logic [1:0]         r_cmd_burst,
  output logic [2:0]         r_cmd_size
);

  typedef enum logic [1:0] {IDLE, WR, RD, FIN} state_t;

  localparam logic [2:0] CMD_SIZE = 3'($clog2(STRB_WD));
  localparam bit GAP_ON =
`ifdef AXI_CMD_GEN_GAP_EN
    (GAP_CYCLES != 0);
`else
    1'b0 && (GAP_CYCLES != 0);
`endif

`ifdef AXI_CMD_GEN_GAP_EN
  localparam int GAP_WD = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;
  logic [GAP_WD-1:0] gap_q, gap_d;
`endif

  state_t             state_q, state_d;
  logic [ADDR_WD-1:0] base_q, base_d, total_q, total_d, chunk_q, chunk_d;
  logic [ADDR_WD-1:0] ptr_q, ptr_d, rem_q, rem_d, addr_q, addr_d, len_q, len_d;
  logic               w_valid_q, w_valid_d, r_valid_q, r_valid_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic [15:0]        w_cnt_q, w_cnt_d, r_cnt_q, r_cnt_d;

  logic               cur_valid, cur_ready, hs, last, present_ok;
  logic [ADDR_WD-1:0] ptr_nxt, rem_nxt;

  function automatic logic [ADDR_WD-1:0] min_len(input logic [ADDR_WD-1:0] a,
                                                 input logic [ADDR_WD-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      base_q    <= '0;
      total_q   <= '0;
      chunk_q   <= '0;
      ptr_q     <= '0;
      rem_q     <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      w_valid_q <= 1'b0;
      r_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      w_cnt_q   <= '0;
      r_cnt_q   <= '0;
`ifdef AXI_CMD_GEN_GAP_EN
      gap_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      total_q   <= total_d;
      chunk_q   <= chunk_d;
      ptr_q     <= ptr_d;
      rem_q     <= rem_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      w_valid_q <= w_valid_d;
      r_valid_q <= r_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      w_cnt_q   <= w_cnt_d;
      r_cnt_q   <= r_cnt_d;
`ifdef AXI_CMD_GEN_GAP_EN
      gap_q     <= gap_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    total_d   = total_q;
    chunk_d   = chunk_q;
    ptr_d     = ptr_q;
    rem_d     = rem_q;
    addr_d    = addr_q;
    len_d     = len_q;
    w_valid_d = w_valid_q;
    r_valid_d = r_valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    w_cnt_d   = w_cnt_q;
    r_cnt_d   = r_cnt_q;
    cur_valid = (state_q == WR) ? w_valid_q : r_valid_q;
    cur_ready = (state_q == WR) ? w_cmd_ready : r_cmd_ready;
    hs        = cur_valid && cur_ready;
    ptr_nxt   = ptr_q + len_q;
    rem_nxt   = rem_q - len_q;
    last      = (rem_nxt == '0);
`ifdef AXI_CMD_GEN_GAP_EN
    gap_d      = (gap_q != '0) ? gap_q - GAP_WD'(1) : gap_q;
    present_ok = (gap_q <= GAP_WD'(1));
`else
    present_ok = 1'b1;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d  = base_addr;
          total_d = total_len;
          chunk_d = (chunk_len == '0) ? total_len : chunk_len;
          ptr_d   = base_addr;
          rem_d   = total_len;
          w_cnt_d = '0;
          r_cnt_d = '0;
          busy_d  = 1'b1;
`ifdef AXI_CMD_GEN_GAP_EN
          gap_d   = '0;
`endif
          state_d = (total_len == '0) ? FIN : WR;
        end
      end
      WR, RD: begin
        if (hs) begin
          ptr_d = ptr_nxt;
          rem_d = rem_nxt;
          if (state_q == WR) w_cnt_d = sat_inc(w_cnt_q);
          else               r_cnt_d = sat_inc(r_cnt_q);
`ifdef AXI_CMD_GEN_GAP_EN
          gap_d = GAP_WD'(GAP_CYCLES);
`endif
          if (last) begin
            // Region exhausted: rewind so the read pass covers the same bytes.
            w_valid_d = 1'b0;
            r_valid_d = 1'b0;
            ptr_d     = base_q;
            rem_d     = total_q;
            state_d   = (state_q == WR) ? RD : FIN;
          end else if (GAP_ON) begin
            w_valid_d = 1'b0;
            r_valid_d = 1'b0;
          end else begin
            addr_d = ptr_nxt;
            len_d  = min_len(chunk_q, rem_nxt);
          end
        end else if (!cur_valid && present_ok) begin
          if (state_q == WR) w_valid_d = 1'b1;
          else               r_valid_d = 1'b1;
          addr_d = ptr_q;
          len_d  = min_len(chunk_q, rem_q);
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign w_cmd_cnt   = w_cnt_q;
  assign r_cmd_cnt   = r_cnt_q;
  assign w_cmd_valid = w_valid_q;
  assign w_cmd_addr  = addr_q;
  assign w_cmd_len   = len_q;
  assign w_cmd_burst = 2'b01;
  assign w_cmd_size  = CMD_SIZE;
  assign r_cmd_valid = r_valid_q;
  assign r_cmd_addr  = addr_q;
  assign r_cmd_len   = len_q;
  assign r_cmd_burst = 2'b01;
  assign r_cmd_size  = CMD_SIZE;

endmodule

// File: tb/tb_axi_cmd_gen.sv
// tb/tb_axi_cmd_gen.sv - directed self-checking bench for axi_cmd_gen
// Build with AXI_CMD_GEN_GAP_EN to expect GAP_CYCLES idle cycles between handshakes.
module tb_axi_cmd_gen;
  localparam int GAP = 4;
`ifdef AXI_CMD_GEN_GAP_EN
  localparam int EXP_INT = GAP + 1;
`else
  localparam int EXP_INT = 1;
`endif

  logic        clk, reset, start;
  logic [31:0] base_addr, total_len, chunk_len;
  logic        busy, done;
  logic [15:0] w_cmd_cnt, r_cmd_cnt;
  logic        w_cmd_valid, w_cmd_ready, r_cmd_valid, r_cmd_ready;
  logic [31:0] w_cmd_addr, w_cmd_len, r_cmd_addr, r_cmd_len;
  logic [1:0]  w_cmd_burst, r_cmd_burst;
  logic [2:0]  w_cmd_size, r_cmd_size;

  axi_cmd_gen #(.ADDR_WD(32), .DATA_WD(32), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset), .start(start),
    .base_addr(base_addr), .total_len(total_len), .chunk_len(chunk_len),
    .busy(busy), .done(done), .w_cmd_cnt(w_cmd_cnt), .r_cmd_cnt(r_cmd_cnt),
    .w_cmd_valid(w_cmd_valid), .w_cmd_ready(w_cmd_ready), .w_cmd_addr(w_cmd_addr),
    .w_cmd_len(w_cmd_len), .w_cmd_burst(w_cmd_burst), .w_cmd_size(w_cmd_size),
    .r_cmd_valid(r_cmd_valid), .r_cmd_ready(r_cmd_ready), .r_cmd_addr(r_cmd_addr),
    .r_cmd_len(r_cmd_len), .r_cmd_burst(r_cmd_burst), .r_cmd_size(r_cmd_size)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rmode = 0;
  int done_cnt = 0;
  int busy_cnt = 0;
  logic [31:0] wq_a[$], wq_l[$], rq_a[$], rq_l[$];
  logic [31:0] ea[$], el[$];
  int wc[$];
  logic pw_v = 1'b0, pw_r = 1'b0, pr_v = 1'b0, pr_r = 1'b0;
  logic [31:0] pw_a = '0, pw_l = '0, pr_a = '0, pr_l = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    w_cmd_ready = 1'b1;
    r_cmd_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1: begin
          w_cmd_ready = ($urandom_range(0, 99) < 30);
          r_cmd_ready = ($urandom_range(0, 99) < 30);
        end
        2: begin
          w_cmd_ready = 1'b0;
          r_cmd_ready = 1'b0;
        end
        default: begin
          w_cmd_ready = 1'b1;
          r_cmd_ready = 1'b1;
        end
      endcase
    end
  end

  // Channel monitor: exclusivity, hold-while-stalled, and capture of accepted commands.
  always @(negedge clk) begin
    check("valid_excl", w_cmd_valid && r_cmd_valid, 1'b0);
    if (!reset && pw_v && !pw_r) begin
      check("w_hold_valid", w_cmd_valid, 1'b1);
      check("w_hold_addr", w_cmd_addr, pw_a);
      check("w_hold_len", w_cmd_len, pw_l);
    end
    if (!reset && pr_v && !pr_r) begin
      check("r_hold_valid", r_cmd_valid, 1'b1);
      check("r_hold_addr", r_cmd_addr, pr_a);
      check("r_hold_len", r_cmd_len, pr_l);
    end
    if (w_cmd_valid && w_cmd_ready) begin
      wq_a.push_back(w_cmd_addr);
      wq_l.push_back(w_cmd_len);
      wc.push_back(cyc);
    end
    if (r_cmd_valid && r_cmd_ready) begin
      rq_a.push_back(r_cmd_addr);
      rq_l.push_back(r_cmd_len);
    end
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    pw_v = w_cmd_valid; pw_r = w_cmd_ready; pw_a = w_cmd_addr; pw_l = w_cmd_len;
    pr_v = r_cmd_valid; pr_r = r_cmd_ready; pr_a = r_cmd_addr; pr_l = r_cmd_len;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [31:0] b, input logic [31:0] t, input logic [31:0] c);
    base_addr = b;
    total_len = t;
    chunk_len = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int maxc);
    int n = 0;
    while (!done && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done_seen"}, done, 1'b1);
    check({tag, "_busy_at_done"}, busy, 1'b0);
  endtask

  task automatic verify(input string tag, input int wb, input int rb);
    check({tag, "_w_num"}, wq_a.size() - wb, ea.size());
    check({tag, "_r_num"}, rq_a.size() - rb, ea.size());
    for (int i = 0; i < ea.size(); i++) begin
      if (wb + i < wq_a.size()) begin
        check($sformatf("%s_w%0d_addr", tag, i), wq_a[wb+i], ea[i]);
        check($sformatf("%s_w%0d_len", tag, i), wq_l[wb+i], el[i]);
      end
      if (rb + i < rq_a.size()) begin
        check($sformatf("%s_r%0d_addr", tag, i), rq_a[rb+i], ea[i]);
        check($sformatf("%s_r%0d_len", tag, i), rq_l[rb+i], el[i]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int wb, rb, db, bb, wcb, n;
    reset = 1'b1; start = 1'b0;
    base_addr = '0; total_len = '0; chunk_len = '0;
    tick(3);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_wvalid", w_cmd_valid, 1'b0);
    check("rst_rvalid", r_cmd_valid, 1'b0);
    check("rst_waddr", w_cmd_addr, 32'h0);
    check("rst_rlen", r_cmd_len, 32'h0);
    check("rst_wcnt", w_cmd_cnt, 16'h0);
    check("rst_rcnt", r_cmd_cnt, 16'h0);
    reset = 1'b0;
    tick(1);

    // Even split, ready always high
    wb = wq_a.size(); rb = rq_a.size(); db = done_cnt; wcb = wc.size();
    pulse_start(32'h0, 32'h1000, 32'h400);
    check("t1_busy_c1", busy, 1'b1);
    check("t1_wvalid_c1", w_cmd_valid, 1'b0);
    tick(1);
    check("t1_wvalid_c2", w_cmd_valid, 1'b1);
    check("t1_waddr_c2", w_cmd_addr, 32'h0);
    check("t1_wlen_c2", w_cmd_len, 32'h400);
    wait_done("t1", 300);
    check("t1_wcnt", w_cmd_cnt, 16'd4);
    check("t1_rcnt", r_cmd_cnt, 16'd4);
    tick(1);
    check("t1_done_low", done, 1'b0);
    tick(1);
    check("t1_done_pulses", done_cnt - db, 1);
    check("t1_wburst", w_cmd_burst, 2'b01);
    check("t1_rburst", r_cmd_burst, 2'b01);
    check("t1_wsize", w_cmd_size, 3'd2);
    check("t1_rsize", r_cmd_size, 3'd2);
    ea = '{32'h0, 32'h400, 32'h800, 32'hC00};
    el = '{32'h400, 32'h400, 32'h400, 32'h400};
    verify("t1", wb, rb);
    for (int i = 1; i < 4; i++)
      if (wcb + i < wc.size())
        check($sformatf("t1_interval%0d", i), wc[wcb+i] - wc[wcb+i-1], EXP_INT);

    // Short final chunk
    wb = wq_a.size(); rb = rq_a.size();
    pulse_start(32'h100, 32'hA50, 32'h400);
    wait_done("t2", 300);
    check("t2_wcnt", w_cmd_cnt, 16'd3);
    check("t2_rcnt", r_cmd_cnt, 16'd3);
    tick(2);
    ea = '{32'h100, 32'h500, 32'h900};
    el = '{32'h400, 32'h400, 32'h250};
    verify("t2", wb, rb);

    // Same region under random backpressure
    wb = wq_a.size(); rb = rq_a.size(); db = done_cnt;
    rmode = 1;
    pulse_start(32'h100, 32'hA50, 32'h400);
    wait_done("t3", 3000);
    rmode = 0;
    tick(2);
    check("t3_done_pulses", done_cnt - db, 1);
    verify("t3", wb, rb);

    // Empty region
    wb = wq_a.size(); rb = rq_a.size(); db = done_cnt; bb = busy_cnt;
    pulse_start(32'h40, 32'h0, 32'h10);
    wait_done("t4", 10);
    tick(2);
    check("t4_busy_cycles", busy_cnt - bb, 1);
    check("t4_done_pulses", done_cnt - db, 1);
    check("t4_wcnt", w_cmd_cnt, 16'd0);
    check("t4_rcnt", r_cmd_cnt, 16'd0);
    ea.delete(); el.delete();
    verify("t4", wb, rb);

    // Zero chunk means one command covering the whole region
    wb = wq_a.size(); rb = rq_a.size();
    pulse_start(32'h40, 32'h80, 32'h0);
    wait_done("t5", 100);
    tick(2);
    check("t5_wcnt", w_cmd_cnt, 16'd1);
    ea = '{32'h40};
    el = '{32'h80};
    verify("t5", wb, rb);

    // Address wrap, start re-pulsed mid-sequence
    wb = wq_a.size(); rb = rq_a.size(); db = done_cnt;
    pulse_start(32'hFFFF_FC00, 32'h800, 32'h400);
    tick(1);
    pulse_start(32'h1234, 32'h10, 32'h8);
    wait_done("t6", 300);
    tick(2);
    check("t6_done_pulses", done_cnt - db, 1);
    check("t6_wcnt", w_cmd_cnt, 16'd2);
    check("t6_rcnt", r_cmd_cnt, 16'd2);
    ea = '{32'hFFFF_FC00, 32'h0};
    el = '{32'h400, 32'h400};
    verify("t6", wb, rb);

    // Reset while a write command is presented
    pulse_start(32'h0, 32'h1000, 32'h400);
    n = 0;
    while (!(w_cmd_valid && w_cmd_cnt != 16'd0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t7_valid_before_rst", w_cmd_valid, 1'b1);
    reset = 1'b1;
    tick(1);
    check("t7_wvalid", w_cmd_valid, 1'b0);
    check("t7_busy", busy, 1'b0);
    check("t7_done", done, 1'b0);
    check("t7_wcnt", w_cmd_cnt, 16'd0);
    check("t7_addr", w_cmd_addr, 32'h0);
    reset = 1'b0;
    db = done_cnt; wb = wq_a.size(); rb = rq_a.size();
    tick(20);
    check("t7_no_done", done_cnt - db, 0);
    check("t7_no_wcmd", wq_a.size() - wb, 0);
    check("t7_no_rcmd", rq_a.size() - rb, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
